// File: rtl/nco_quad_mixer_if.sv
// Sample/control bundle between the DSP chain and the NCO quadrature mixer.
// The master drives samples and tuning; the slave (mixer) returns results and status.
interface nco_quad_mixer_if #(
   parameter int DATA_W  = 16,
   parameter int PHASE_W = 24
);
   logic                      tick_i;
   logic signed [DATA_W-1:0]  in_r_i;
   logic signed [DATA_W-1:0]  in_i_i;
   logic        [PHASE_W-1:0] freq_word_i;
   logic        [PHASE_W-1:0] phase_off_i;
   logic        [1:0]         mode_i;
   logic                      phase_clr_i;
   logic signed [DATA_W-1:0]  out_r_o;
   logic signed [DATA_W-1:0]  out_i_o;
   logic                      valid_o;
   logic                      busy_o;
   logic                      sat_o;
   logic                      overrun_o;

   modport master (
      output tick_i, in_r_i, in_i_i, freq_word_i, phase_off_i, mode_i, phase_clr_i,
      input  out_r_o, out_i_o, valid_o, busy_o, sat_o, overrun_o
   );

   modport slave (
      input  tick_i, in_r_i, in_i_i, freq_word_i, phase_off_i, mode_i, phase_clr_i,
      output out_r_o, out_i_o, valid_o, busy_o, sat_o, overrun_o
   );
endinterface

// File: rtl/nco_quad_mixer.sv
// Complex frequency shifter: phase-accumulator NCO, quarter-wave sine ROM and one
// time-shared multiplier; one result per accepted tick, 8 clocks after the tick.
//
// state | meaning
// IDLE  | waiting for tick_i; latches sample, mode and lookup phase
// ADDR  | register ROM addresses and quadrant signs
// FETCH | register signed sine/cosine
// M0    | accR  = a*c
// M1    | accR += -/+ b*s
// M2    | accI  = b*c
// M3    | accI += +/- a*s
// ROUND | round, shift, saturate; load output registers
// OUT   | valid_o high, return to IDLE
module nco_quad_mixer #(
   parameter int DATA_W  = 16,
   parameter int PHASE_W = 24,
   parameter int LUT_AW  = 8,
   parameter int AMP_W   = 16
) (
   input  logic            clk_i,
   input  logic            reset_i,
   nco_quad_mixer_if.slave bus
);

   localparam int N         = 1 << LUT_AW;
   localparam int TOP_W     = LUT_AW + 2;
   localparam int TOP_SHIFT = PHASE_W - TOP_W;
   localparam int PROD_W    = DATA_W + AMP_W;
   localparam int ACC_W     = DATA_W + AMP_W + 1;

   localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1) << (AMP_W - 2);
   localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
   localparam logic signed [ACC_W-1:0] OUT_MIN  = ~OUT_MAX;

   // Integer Taylor series in Q30 so the ROM contents are fixed at elaboration
   // without relying on real-valued math in constant functions.
   function automatic logic signed [AMP_W-1:0] lut_entry(input int k);
      longint x, x2, term, sum, peak;
      peak = (64'sd1 <<< (AMP_W - 1)) - 64'sd1;
      x    = (longint'(2 * k + 1) * 64'sd3373259426) >>> (LUT_AW + 2);
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int n = 1; n <= 7; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      return AMP_W'((sum * peak + 64'sd536870912) >>> 30);
   endfunction

   logic signed [AMP_W-1:0] lut_rom [N];

   for (genvar k = 0; k < N; k++) begin : g_lut
      localparam logic signed [AMP_W-1:0] L = lut_entry(k);
      assign lut_rom[k] = L;
   end

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_FETCH, S_M0, S_M1, S_M2, S_M3, S_ROUND, S_OUT
   } state_t;

   state_t state_q, state_d;

   logic        [PHASE_W-1:0] acc_q;
   logic        [PHASE_W-1:0] phase_base;
   logic signed [DATA_W-1:0]  a_q, b_q;
   logic        [1:0]         mode_q;
   logic        [TOP_W-1:0]   p_top_q;
   logic        [1:0]         quad;
   logic        [LUT_AW-1:0]  idx;
   logic        [LUT_AW-1:0]  addr_s_q, addr_c_q;
   logic                      neg_s_q, neg_c_q;
   logic signed [AMP_W-1:0]   s_q, c_q;
   logic signed [DATA_W-1:0]  mul_a;
   logic signed [AMP_W-1:0]   mul_b;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   acc_r_q, acc_i_q;
   logic signed [ACC_W-1:0]   sh_r, sh_i;
   logic signed [DATA_W-1:0]  rnd_r, rnd_i;
   logic                      clip_r, clip_i;
   logic signed [DATA_W-1:0]  out_r_q, out_i_q;
   logic                      valid_q, sat_q, overrun_q;
   logic                      accept, up, bypass;

   assign accept     = (state_q == S_IDLE) && bus.tick_i;
   assign phase_base = bus.phase_clr_i ? '0 : acc_q;
   assign quad       = p_top_q[TOP_W-1 -: 2];
   assign idx        = p_top_q[LUT_AW-1:0];
   assign up         = (mode_q == 2'b10);
   assign bypass     = (mode_q == 2'b00) || (mode_q == 2'b11);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.tick_i) state_d = S_ADDR;
         S_ADDR:  state_d = S_FETCH;
         S_FETCH: state_d = S_M0;
         S_M0:    state_d = S_M1;
         S_M1:    state_d = S_M2;
         S_M2:    state_d = S_M3;
         S_M3:    state_d = S_ROUND;
         S_ROUND: state_d = S_OUT;
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Phase clear without a tick is honoured in any state.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)                acc_q <= '0;
      else if (accept)            acc_q <= phase_base + bus.freq_word_i;
      else if (bus.phase_clr_i)   acc_q <= '0;
   end

   always_comb begin
      mul_a = a_q;
      mul_b = c_q;
      case (state_q)
         S_M1:    begin mul_a = b_q; mul_b = s_q; end
         S_M2:    begin mul_a = b_q; mul_b = c_q; end
         S_M3:    begin mul_a = a_q; mul_b = s_q; end
         default: ;
      endcase
   end

   assign prod     = PROD_W'(mul_a) * PROD_W'(mul_b);
   assign prod_ext = ACC_W'(prod);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         a_q      <= '0;
         b_q      <= '0;
         mode_q   <= '0;
         p_top_q  <= '0;
         addr_s_q <= '0;
         addr_c_q <= '0;
         neg_s_q  <= 1'b0;
         neg_c_q  <= 1'b0;
         s_q      <= '0;
         c_q      <= '0;
         acc_r_q  <= '0;
         acc_i_q  <= '0;
      end else begin
         if (accept) begin
            a_q     <= bus.in_r_i;
            b_q     <= bus.in_i_i;
            mode_q  <= bus.mode_i;
            p_top_q <= TOP_W'((phase_base + bus.phase_off_i) >> TOP_SHIFT);
         end
         case (state_q)
            S_ADDR: begin
               addr_s_q <= quad[0] ? ~idx : idx;
               addr_c_q <= quad[0] ? idx : ~idx;
               neg_s_q  <= quad[1];
               neg_c_q  <= quad[1] ^ quad[0];
            end
            S_FETCH: begin
               s_q <= neg_s_q ? -lut_rom[addr_s_q] : lut_rom[addr_s_q];
               c_q <= neg_c_q ? -lut_rom[addr_c_q] : lut_rom[addr_c_q];
            end
            S_M0:    acc_r_q <= prod_ext;
            S_M1:    acc_r_q <= up ? acc_r_q - prod_ext : acc_r_q + prod_ext;
            S_M2:    acc_i_q <= prod_ext;
            S_M3:    acc_i_q <= up ? acc_i_q + prod_ext : acc_i_q - prod_ext;
            default: ;
         endcase
      end
   end

   always_comb begin
      sh_r   = (acc_r_q + RND_BIAS) >>> (AMP_W - 1);
      sh_i   = (acc_i_q + RND_BIAS) >>> (AMP_W - 1);
      clip_r = (sh_r > OUT_MAX) || (sh_r < OUT_MIN);
      clip_i = (sh_i > OUT_MAX) || (sh_i < OUT_MIN);
      rnd_r  = (sh_r > OUT_MAX) ? OUT_MAX[DATA_W-1:0] :
               (sh_r < OUT_MIN) ? OUT_MIN[DATA_W-1:0] : sh_r[DATA_W-1:0];
      rnd_i  = (sh_i > OUT_MAX) ? OUT_MAX[DATA_W-1:0] :
               (sh_i < OUT_MIN) ? OUT_MIN[DATA_W-1:0] : sh_i[DATA_W-1:0];
   end

   // Results land on the ROUND->OUT edge so valid_o and the data coincide in OUT.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         out_r_q   <= '0;
         out_i_q   <= '0;
         valid_q   <= 1'b0;
         sat_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         valid_q <= (state_q == S_ROUND);
         sat_q   <= (state_q == S_ROUND) && !bypass && (clip_r || clip_i);
         if (state_q == S_ROUND) begin
            out_r_q <= bypass ? a_q : rnd_r;
            out_i_q <= bypass ? b_q : rnd_i;
         end
         if (bus.tick_i && (state_q != S_IDLE)) overrun_q <= 1'b1;
      end
   end

   assign bus.out_r_o   = out_r_q;
   assign bus.out_i_o   = out_i_q;
   assign bus.valid_o   = valid_q;
   assign bus.sat_o     = sat_q;
   assign bus.overrun_o = overrun_q;
   assign bus.busy_o    = (state_q != S_IDLE);

endmodule
